// File: rtl/gray_seq_if.sv
// Command and status bundle between a control master and gray_seq_ctrl.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
// cmd_ready depends only on the sequencer state, never on cmd_valid.
interface gray_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_arg;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             step;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_arg,
    input  cmd_ready, gray_out, bin_out, step, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_arg,
    output cmd_ready, gray_out, bin_out, step, busy, done
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer stepping a Gray-code counter with a binary shadow.
// Supports RUN_N, LOAD, FREE_RUN and STOP; state is exported on state_dbg.
module gray_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  gray_seq_if.slave    bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    FREE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_FREE = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  state_t           state;
  logic             dir_q;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             step_q;
  logic             done_q;

  logic             accept;
  logic             adv_dir;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] load_val;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign bus.cmd_ready = (state == IDLE) || (state == FREE);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign load_val      = bus.cmd_arg[WIDTH-1:0];

  // A FREE_RUN re-issued while free-running steps in the new direction on the same edge.
  assign adv_dir  = (state == FREE && accept && bus.cmd_op == OP_FREE) ? bus.cmd_dir : dir_q;
  assign bin_next = adv_dir ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      remaining <= '0;
      bin_q     <= '0;
      gray_q    <= '0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE, FREE: begin
          if (accept) begin
            case (bus.cmd_op)
              OP_RUN: begin
                if (bus.cmd_arg != '0) begin
                  remaining <= bus.cmd_arg;
                  dir_q     <= bus.cmd_dir;
                  state     <= COUNT;
                end else begin
                  done_q <= 1'b1;
                  state  <= IDLE;
                end
              end
              OP_LOAD: begin
                bin_q  <= load_val;
                gray_q <= to_gray(load_val);
                state  <= IDLE;
              end
              OP_FREE: begin
                dir_q <= bus.cmd_dir;
                state <= FREE;
                if (state == FREE) begin
                  bin_q  <= bin_next;
                  gray_q <= to_gray(bin_next);
                  step_q <= 1'b1;
                end
              end
              OP_STOP: state <= IDLE;
              default: state <= IDLE;
            endcase
          end else if (state == FREE) begin
            bin_q  <= bin_next;
            gray_q <= to_gray(bin_next);
            step_q <= 1'b1;
          end
        end
        COUNT: begin
          bin_q     <= bin_next;
          gray_q    <= to_gray(bin_next);
          step_q    <= 1'b1;
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.bin_out  = bin_q;
  assign bus.step     = step_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);
  assign state_dbg    = state;

endmodule
